// File: rtl/cpu_irq_pkg.sv
// Shared types and constants for the CPU interrupt controller.
// Holds the FSM states, the register map and the status word layout.
package cpu_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } irq_state_e;

    localparam logic [3:0] ADDR_MASK = 4'h8;
    localparam logic [3:0] ADDR_PEND = 4'h9;
    localparam logic [3:0] ADDR_EN   = 4'hA;
    localparam logic [3:0] ADDR_STAT = 4'hB;

    localparam int STAT_GRANT_LSB = 0;
    localparam int STAT_STATE_LSB = 3;

    typedef struct packed {
        irq_state_e state;
        logic [2:0] grantId;
    } irq_status_t;

    function automatic logic [31:0] status_word(
        input irq_state_e s,
        input logic [2:0] g
    );
        irq_status_t st;
        st.state   = s;
        st.grantId = g;
        return {27'd0, st};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending sources.
// Reports whether any request is present and the winning index.
module irq_prio_enc #(
    parameter int N_SRC = 8
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [2:0]       idx
);

    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        // Scan downwards so the lowest set bit is the last one to assign
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with a 4-state request/ack handshake.
// Sources latch into pending, the lowest enabled one is granted to the CPU.
module irq_controller #(
    parameter int N_SRC   = 8,
    parameter int HOLDOFF = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic [N_SRC-1:0] irqSrc,
    input  logic             cfgWrEn,
    input  logic [3:0]       cfgAddr,
    input  logic [31:0]      cfgDataIn,
    output logic [31:0]      cfgDataOut,
    output logic             IRQ,
    output logic [11:0]      IRQn,
    input  logic             IRQAck
);
    import cpu_irq_pkg::*;

    localparam int          HOLD_CYC  = (HOLDOFF < 1) ? 1 : HOLDOFF;
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYC - 1);

    irq_state_e       state;
    irq_state_e       stateNext;
    logic [N_SRC-1:0] srcQ;
    logic [N_SRC-1:0] srcRise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] pendNext;
    logic [N_SRC-1:0] pendClr;
    logic [N_SRC-1:0] ackClr;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] armedReq;
    logic [11:0]      vector [8];
    logic             globalEn;
    logic             armed;
    logic [2:0]       grantId;
    logic [2:0]       encIdx;
    logic             encValid;
    logic             grantLoad;
    logic             ackHit;
    logic             holdClr;
    logic             holdInc;
    logic [15:0]      holdCnt;
    logic             hitVec;
    logic             hitMask;
    logic             hitPend;
    logic             hitEn;
    logic             hitStat;
    logic             unusedBits;

    assign unusedBits = ^cfgDataIn[31:12];

    assign hitVec  = !cfgAddr[3] && (int'(cfgAddr[2:0]) < N_SRC);
    assign hitMask = (cfgAddr == ADDR_MASK);
    assign hitPend = (cfgAddr == ADDR_PEND);
    assign hitEn   = (cfgAddr == ADDR_EN);
    assign hitStat = (cfgAddr == ADDR_STAT);

    // armed masks the first sample after reset so lines already high are not edges
    assign srcRise = irqSrc & ~srcQ & {N_SRC{armed}};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            srcQ  <= '0;
            armed <= 1'b0;
        end else begin
            srcQ  <= irqSrc;
            armed <= 1'b1;
        end
    end

    always_comb begin
        ackClr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            ackClr[i] = ackHit && (grantId == 3'(i));
        end
    end

    assign pendClr  = ((cfgWrEn && hitPend) ? cfgDataIn[N_SRC-1:0] : '0)
                    | ackClr;
    assign pendNext = (pending & ~pendClr) | srcRise;
    assign armedReq = pending & mask;

    irq_prio_enc #(
        .N_SRC(N_SRC)
    ) u_prio (
        .req  (armedReq),
        .valid(encValid),
        .idx  (encIdx)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pending  <= '0;
            mask     <= '0;
            globalEn <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                vector[i] <= '0;
            end
        end else begin
            pending <= pendNext;
            if (cfgWrEn && hitVec) begin
                vector[cfgAddr[2:0]] <= cfgDataIn[11:0];
            end
            if (cfgWrEn && hitMask) begin
                mask <= cfgDataIn[N_SRC-1:0];
            end
            if (cfgWrEn && hitEn) begin
                globalEn <= cfgDataIn[0];
            end
        end
    end

    always_comb begin
        stateNext = state;
        grantLoad = 1'b0;
        ackHit    = 1'b0;
        holdClr   = 1'b0;
        holdInc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (globalEn && encValid) begin
                    stateNext = ST_REQ;
                    grantLoad = 1'b1;
                end
            end
            ST_REQ: begin
                if (IRQAck) begin
                    stateNext = ST_ACK;
                    ackHit    = 1'b1;
                end
            end
            ST_ACK: begin
                if (!IRQAck) begin
                    stateNext = ST_HOLD;
                    holdClr   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (holdCnt == HOLD_LAST) begin
                    stateNext = ST_IDLE;
                end else begin
                    holdInc = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state   <= ST_IDLE;
            grantId <= '0;
            IRQn    <= '0;
            holdCnt <= '0;
        end else begin
            state <= stateNext;
            // Vector is captured at grant so later writes cannot disturb REQ
            if (grantLoad) begin
                grantId <= encIdx;
                IRQn    <= vector[encIdx];
            end
            if (holdClr) begin
                holdCnt <= '0;
            end else if (holdInc) begin
                holdCnt <= holdCnt + 16'd1;
            end
        end
    end

    assign IRQ = (state == ST_REQ);

    always_comb begin
        cfgDataOut = '0;
        unique case (1'b1)
            hitVec:  cfgDataOut = {20'd0, vector[cfgAddr[2:0]]};
            hitMask: cfgDataOut = 32'(mask);
            hitPend: cfgDataOut = 32'(pending);
            hitEn:   cfgDataOut = {31'd0, globalEn};
            hitStat: cfgDataOut = status_word(state, grantId);
            default: cfgDataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: grant timing, priority, no-retract,
// set-wins-over-clear, long acknowledge and asynchronous reset.
module tb_irq_controller;

    logic        clk;
    logic        nRst;
    logic [7:0]  irqSrc;
    logic        cfgWrEn;
    logic [3:0]  cfgAddr;
    logic [31:0] cfgDataIn;
    logic [31:0] cfgDataOut;
    logic        IRQ;
    logic [11:0] IRQn;
    logic        IRQAck;

    int nCmp = 0;
    int nBad = 0;

    irq_controller #(
        .N_SRC  (8),
        .HOLDOFF(4)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .irqSrc    (irqSrc),
        .cfgWrEn   (cfgWrEn),
        .cfgAddr   (cfgAddr),
        .cfgDataIn (cfgDataIn),
        .cfgDataOut(cfgDataOut),
        .IRQ       (IRQ),
        .IRQn      (IRQn),
        .IRQAck    (IRQAck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cfgWrEn   = 1'b1;
        cfgAddr   = a;
        cfgDataIn = d;
        cyc(1);
        cfgWrEn   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a,
                      input logic [31:0] exp);
        cfgAddr = a;
        #1;
        chk(tag, cfgDataOut, exp);
    endtask

    task automatic out(input string tag, input logic expIrq,
                       input logic [11:0] expVec);
        chk({tag, "_irq"}, 32'(IRQ), 32'(expIrq));
        chk({tag, "_vec"}, 32'(IRQn), 32'(expVec));
    endtask

    initial begin
        nRst      = 1'b0;
        irqSrc    = '0;
        cfgWrEn   = 1'b0;
        cfgAddr   = '0;
        cfgDataIn = '0;
        IRQAck    = 1'b0;
        cyc(2);
        out("rst", 1'b0, 12'h000);
        rd("rst_stat", 4'hB, 32'h0);
        rd("rst_mask", 4'h8, 32'h0);
        nRst = 1'b1;
        cyc(2);

        // single source: edge -> pending -> REQ two cycles later
        wr(4'h3, 32'h120);
        wr(4'h8, 32'h08);
        wr(4'hA, 32'h1);
        rd("t1_vec3", 4'h3, 32'h120);
        irqSrc = 8'h08;
        cyc(1);
        irqSrc = 8'h00;
        out("t1_n1", 1'b0, 12'h000);
        rd("t1_pend", 4'h9, 32'h08);
        cyc(1);
        out("t1_n2", 1'b1, 12'h120);
        rd("t1_stat_req", 4'hB, 32'h0B);
        cyc(2);
        out("t1_hold", 1'b1, 12'h120);
        IRQAck = 1'b1;
        cyc(1);
        chk("t1_ack_irq", 32'(IRQ), 32'h0);
        rd("t1_ack_pend", 4'h9, 32'h0);
        rd("t1_stat_ack", 4'hB, 32'h13);
        IRQAck = 1'b0;
        cyc(1);
        rd("t1_stat_hold", 4'hB, 32'h1B);
        cyc(3);
        rd("t1_stat_hold4", 4'hB, 32'h1B);
        cyc(1);
        rd("t1_stat_idle", 4'hB, 32'h03);

        // simultaneous sources 5 and 2: lowest index first
        wr(4'h2, 32'h200);
        wr(4'h5, 32'h500);
        wr(4'h8, 32'hFF);
        irqSrc = 8'h24;
        cyc(1);
        irqSrc = 8'h00;
        cyc(1);
        out("t2_first", 1'b1, 12'h200);
        rd("t2_pend", 4'h9, 32'h24);
        IRQAck = 1'b1;
        cyc(1);
        rd("t2_pend_ack", 4'h9, 32'h20);
        IRQAck = 1'b0;
        cyc(1);
        rd("t2_hold", 4'hB, 32'h1A);
        cyc(3);
        chk("t2_hold_irq", 32'(IRQ), 32'h0);
        cyc(1);
        rd("t2_idle", 4'hB, 32'h02);
        cyc(1);
        out("t2_second", 1'b1, 12'h500);
        rd("t2_stat5", 4'hB, 32'h0D);
        IRQAck = 1'b1;
        cyc(1);
        IRQAck = 1'b0;
        cyc(5);

        // no retraction while in REQ
        wr(4'h1, 32'h111);
        irqSrc = 8'h02;
        cyc(1);
        irqSrc = 8'h00;
        cyc(1);
        out("t3_grant", 1'b1, 12'h111);
        wr(4'h8, 32'h00);
        wr(4'hA, 32'h0);
        wr(4'h1, 32'h3FF);
        wr(4'h9, 32'h02);
        out("t3_kept", 1'b1, 12'h111);
        IRQAck = 1'b1;
        cyc(1);
        chk("t3_ack_irq", 32'(IRQ), 32'h0);
        IRQAck = 1'b0;
        cyc(5);
        wr(4'h8, 32'h02);
        wr(4'hA, 32'h1);
        irqSrc = 8'h02;
        cyc(1);
        irqSrc = 8'h00;
        cyc(1);
        out("t3_newvec", 1'b1, 12'h3FF);
        IRQAck = 1'b1;
        cyc(1);
        IRQAck = 1'b0;
        cyc(5);

        // edge coinciding with write-1-to-clear: set wins
        wr(4'hA, 32'h0);
        irqSrc = 8'h01;
        cyc(1);
        irqSrc = 8'h00;
        cyc(1);
        rd("t4_pend_set", 4'h9, 32'h01);
        irqSrc = 8'h01;
        wr(4'h9, 32'h01);
        rd("t4_set_wins", 4'h9, 32'h01);
        wr(4'h9, 32'h01);
        rd("t4_cleared", 4'h9, 32'h00);

        // acknowledge held for 20 cycles
        wr(4'h0, 32'h0AB);
        wr(4'h8, 32'h01);
        wr(4'hA, 32'h1);
        irqSrc = 8'h00;
        cyc(1);
        irqSrc = 8'h01;
        cyc(2);
        out("t5_grant", 1'b1, 12'h0AB);
        IRQAck = 1'b1;
        cyc(1);
        rd("t5_ack", 4'hB, 32'h10);
        cyc(19);
        rd("t5_ack20", 4'hB, 32'h10);
        chk("t5_ack20_irq", 32'(IRQ), 32'h0);
        IRQAck = 1'b0;
        cyc(1);
        rd("t5_hold", 4'hB, 32'h18);
        IRQAck = 1'b1;
        cyc(3);
        rd("t5_hold4", 4'hB, 32'h18);
        cyc(1);
        rd("t5_idle", 4'hB, 32'h00);
        IRQAck = 1'b0;
        cyc(2);
        chk("t5_quiet", 32'(IRQ), 32'h0);

        // asynchronous reset in the middle of REQ
        wr(4'h3, 32'h120);
        wr(4'h8, 32'h09);
        irqSrc = 8'h09;
        cyc(2);
        out("t6_grant", 1'b1, 12'h120);
        #2;
        nRst = 1'b0;
        #1;
        out("t6_async", 1'b0, 12'h000);
        rd("t6_stat_async", 4'hB, 32'h0);
        @(posedge clk);
        #1;
        nRst = 1'b1;
        rd("t6_vec3", 4'h3, 32'h0);
        rd("t6_mask", 4'h8, 32'h0);
        rd("t6_pend", 4'h9, 32'h0);
        rd("t6_en", 4'hA, 32'h0);
        rd("t6_stat", 4'hB, 32'h0);
        wr(4'h8, 32'hFF);
        wr(4'hA, 32'h1);
        cyc(4);
        chk("t6_no_grant", 32'(IRQ), 32'h0);
        rd("t6_no_pend", 4'h9, 32'h0);
        irqSrc = 8'h00;
        cyc(1);
        irqSrc = 8'h08;
        cyc(2);
        out("t6_regrant", 1'b1, 12'h000);
        rd("t6_stat_re", 4'hB, 32'h0B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
